// File: rtl/spi_qsys_nios2_qsys_0_ocimem_arbiter_if.sv
// CPU Avalon-MM slave port and single-port debug RAM port of the OCI memory arbiter.
// The arbiter uses the slave modport; the CPU/RAM environment uses the master modport.
interface spi_qsys_nios2_qsys_0_ocimem_arbiter_if #(parameter int ADDR_W = 8);
   logic [ADDR_W-1:0] av_address;
   logic              av_read;
   logic              av_write;
   logic [31:0]       av_writedata;
   logic [3:0]        av_byteenable;
   logic              debugaccess;
   logic [31:0]       av_readdata;
   logic              av_waitrequest;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [3:0]        ram_byteen;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport slave (
      input  av_address, av_read, av_write, av_writedata, av_byteenable, debugaccess, ram_rdata,
      output av_readdata, av_waitrequest, ram_addr, ram_wren, ram_byteen, ram_wdata
   );

   modport master (
      output av_address, av_read, av_write, av_writedata, av_byteenable, debugaccess, ram_rdata,
      input  av_readdata, av_waitrequest, ram_addr, ram_wren, ram_byteen, ram_wdata
   );
endinterface

// File: rtl/spi_qsys_nios2_qsys_0_ocimem_arbiter.sv
// OCI debug-RAM arbiter: one single-port RAM shared by JTAG debug commands and CPU Avalon accesses.
//  state | meaning
//  IDLE  | arbitrate JTAG request against CPU request
//  J_RD  | JTAG read address presented to RAM
//  J_CAP | JTAG read data captured into MonDReg, jaddr advances
//  J_WR  | JTAG write of jdata, jaddr advances
//  C_RD  | CPU read address presented to RAM
//  C_CAP | CPU read data captured
//  C_ACK | CPU read acknowledged
//  C_WR  | CPU write, acknowledged in the same cycle
module spi_qsys_nios2_qsys_0_ocimem_arbiter #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_no_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   spi_qsys_nios2_qsys_0_ocimem_arbiter_if.slave bus,
   output logic [31:0] MonDReg,
   output logic        jtag_busy,
   output logic        jtag_overrun
);

   typedef enum logic [2:0] {IDLE, J_RD, J_CAP, J_WR, C_RD, C_CAP, C_ACK, C_WR} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] jaddr_q, jaddr_d, ram_addr_q;
   logic [31:0]       jdata_q, jdata_d, mon_q, rdata_q, ram_wdata_q;
   logic [3:0]        ram_byteen_q;
   logic              pend_q, pend_wr_q, last_jtag_q, overrun_q, waitreq_q, ram_wren_q;
   logic              j_active, strb_any, strb_multi, acc_wr, acc_ld, acc_rd, new_req;
   logic              jreq, jreq_wr, cpu_req, grant_j;
   logic              unused_jdo;

   assign unused_jdo = ^jdo;

   // A strobe is accepted only when no JTAG request is posted or in service.
   assign j_active   = pend_q | (state_q == J_RD) | (state_q == J_CAP) | (state_q == J_WR);
   assign strb_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign strb_multi = (take_action_ocimem_b & take_action_ocimem_a)
                     | (take_action_ocimem_b & take_no_action_ocimem_a)
                     | (take_action_ocimem_a & take_no_action_ocimem_a);
   assign acc_wr     = ~j_active & take_action_ocimem_b;
   assign acc_ld     = ~j_active & ~take_action_ocimem_b & take_action_ocimem_a;
   assign acc_rd     = ~j_active & ~take_action_ocimem_b
                     & (take_action_ocimem_a ? jdo[25] : take_no_action_ocimem_a);
   assign new_req    = acc_wr | acc_rd;

   assign jreq    = pend_q | new_req;
   assign jreq_wr = pend_q ? pend_wr_q : acc_wr;
   assign cpu_req = bus.av_read | bus.av_write;
   assign grant_j = jreq & (~cpu_req | ~last_jtag_q);

   always_comb begin
      jaddr_d = jaddr_q;
      if (acc_ld)
         jaddr_d = jdo[26 +: ADDR_W];
      else if ((state_q == J_CAP) || (state_q == J_WR))
         jaddr_d = jaddr_q + ADDR_W'(1);
   end

   assign jdata_d = acc_wr ? jdo[34:3] : jdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         jaddr_q      <= '0;
         jdata_q      <= '0;
         mon_q        <= '0;
         rdata_q      <= '0;
         pend_q       <= 1'b0;
         pend_wr_q    <= 1'b0;
         last_jtag_q  <= 1'b0;
         overrun_q    <= 1'b0;
         waitreq_q    <= 1'b1;
         ram_wren_q   <= 1'b0;
         ram_addr_q   <= '0;
         ram_byteen_q <= '0;
         ram_wdata_q  <= '0;
      end else begin
         jaddr_q   <= jaddr_d;
         jdata_q   <= jdata_d;
         overrun_q <= overrun_q | (strb_any & j_active) | strb_multi;
         if (new_req) begin
            pend_q    <= 1'b1;
            pend_wr_q <= acc_wr;
         end
         unique case (state_q)
            IDLE: begin
               if (grant_j) begin
                  pend_q      <= 1'b0;
                  last_jtag_q <= 1'b1;
                  ram_addr_q  <= jaddr_d;
                  if (jreq_wr) begin
                     state_q      <= J_WR;
                     ram_wren_q   <= 1'b1;
                     ram_byteen_q <= 4'hF;
                     ram_wdata_q  <= jdata_d;
                  end else begin
                     state_q <= J_RD;
                  end
               end else if (cpu_req) begin
                  last_jtag_q <= 1'b0;
                  ram_addr_q  <= bus.av_address;
                  if (bus.av_read) begin
                     state_q <= C_RD;
                  end else begin
                     state_q      <= C_WR;
                     ram_wren_q   <= bus.debugaccess;
                     ram_byteen_q <= bus.av_byteenable;
                     ram_wdata_q  <= bus.av_writedata;
                     waitreq_q    <= 1'b0;
                  end
               end
            end
            J_RD:  state_q <= J_CAP;
            J_CAP: begin
               mon_q   <= bus.ram_rdata;
               state_q <= IDLE;
            end
            J_WR: begin
               ram_wren_q <= 1'b0;
               state_q    <= IDLE;
            end
            C_RD:  state_q <= C_CAP;
            C_CAP: begin
               rdata_q   <= bus.ram_rdata;
               waitreq_q <= 1'b0;
               state_q   <= C_ACK;
            end
            C_ACK: begin
               waitreq_q <= 1'b1;
               state_q   <= IDLE;
            end
            C_WR: begin
               waitreq_q  <= 1'b1;
               ram_wren_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ram_addr       = ram_addr_q;
   assign bus.ram_wren       = ram_wren_q;
   assign bus.ram_byteen     = ram_byteen_q;
   assign bus.ram_wdata      = ram_wdata_q;
   assign bus.av_readdata    = rdata_q;
   assign bus.av_waitrequest = waitreq_q;
   assign MonDReg            = mon_q;
   assign jtag_busy          = j_active;
   assign jtag_overrun       = overrun_q;

endmodule
